// File: rtl/alu_share_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_arb_pkg
// Brief   : Shared encodings for the two-requester ALU sharing arbiter:
//           ALU op codes, arbiter FSM states and requester identifiers.
// Revision: 1.0 - initial release
// ============================================================================
package alu_share_arb_pkg;

  // Shared ALU op encodings (must match the external ALU)
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Requester identifiers (also bit positions in grant vectors)
  localparam logic REQ_R0 = 1'b0;
  localparam logic REQ_R1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/alu_share_arb_rr.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb2
// Brief   : Combinational 2-way round-robin arbiter. A lone valid is granted
//           directly; on a tie the requester that did not win last is chosen.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb2
  import alu_share_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant,
  output logic       o_any
);

  // One-hot grant; tie broken away from the last winner
  always_comb begin
    o_grant = i_valid;
    if (i_valid == 2'b11) begin
      o_grant = 2'b00;
      if (i_last_grant == REQ_R1) begin
        o_grant[REQ_R0] = 1'b1;
      end else begin
        o_grant[REQ_R1] = 1'b1;
      end
    end
  end

  assign o_any = |i_valid;

endmodule
`default_nettype wire

// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module  : alu_share_arb
// Brief   : Shares one external ALU between two valid/ready requesters.
//           Round-robin grant in IDLE, registered operands in EXEC, result
//           held for the granted requester in RESP.
//           Optional build macro ALU_SHARE_ARB_PERF_EN adds saturating
//           grant and stall counters (perf_gnt0, perf_gnt1, perf_stall).
// Revision: 1.0 - initial release
// ============================================================================
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_req_valid,
  output logic             r0_req_ready,
  input  logic [WIDTH-1:0] r0_req_a,
  input  logic [WIDTH-1:0] r0_req_b,
  input  logic [SEL_W-1:0] r0_req_sel,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [WIDTH-1:0] r0_rsp_result,
  input  logic             r1_req_valid,
  output logic             r1_req_ready,
  input  logic [WIDTH-1:0] r1_req_a,
  input  logic [WIDTH-1:0] r1_req_b,
  input  logic [SEL_W-1:0] r1_req_sel,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] r1_rsp_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result
`ifdef ALU_SHARE_ARB_PERF_EN
  ,
  output logic [15:0]      perf_gnt0,
  output logic [15:0]      perf_gnt1,
  output logic [15:0]      perf_stall
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;
  logic             r_gnt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [SEL_W-1:0] r_op_sel;
  logic [WIDTH-1:0] r_res;

  logic [1:0]       w_grant;
  logic             w_any;
  logic             w_accept;
  logic             w_rsp_ready;

  rr_arb2 u_arb (
    .i_valid      ({r1_req_valid, r0_req_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_any        (w_any)
  );

  // A handshake happens only in IDLE, and then always for the granted side
  assign w_accept    = (r_state == ST_IDLE) && w_any;
  assign w_rsp_ready = (r_gnt == REQ_R1) ? r1_rsp_ready : r0_rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt  = r_state;
    r0_req_ready = 1'b0;
    r1_req_ready = 1'b0;
    r0_rsp_valid = 1'b0;
    r1_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        r0_req_ready = w_grant[REQ_R0];
        r1_req_ready = w_grant[REQ_R1];
        if (w_any) begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        r0_rsp_valid = (r_gnt == REQ_R0);
        r1_rsp_valid = (r_gnt == REQ_R1);
        if (w_rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Operand capture on the request handshake, result capture in EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= REQ_R1;
      r_gnt        <= REQ_R0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_op_sel     <= '0;
      r_res        <= '0;
    end else begin
      if (w_accept) begin
        r_gnt        <= w_grant[REQ_R1];
        r_last_grant <= w_grant[REQ_R1];
        if (w_grant[REQ_R1]) begin
          r_op_a   <= r1_req_a;
          r_op_b   <= r1_req_b;
          r_op_sel <= r1_req_sel;
        end else begin
          r_op_a   <= r0_req_a;
          r_op_b   <= r0_req_b;
          r_op_sel <= r0_req_sel;
        end
      end
      if (r_state == ST_EXEC) begin
        r_res <= alu_result;
      end
    end
  end

  // ALU always sees registered operands, never the request ports
  assign alu_a         = r_op_a;
  assign alu_b         = r_op_b;
  assign alu_sel       = r_op_sel;
  assign r0_rsp_result = r_res;
  assign r1_rsp_result = r_res;

`ifdef ALU_SHARE_ARB_PERF_EN
  logic [15:0] r_perf_gnt0;
  logic [15:0] r_perf_gnt1;
  logic [15:0] r_perf_stall;
  logic        w_stall;

  assign w_stall = (r0_req_valid && !r0_req_ready) ||
                   (r1_req_valid && !r1_req_ready);

  // Saturating handshake and stall counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_gnt0  <= '0;
      r_perf_gnt1  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_accept && w_grant[REQ_R0] && (r_perf_gnt0 != 16'hFFFF)) begin
        r_perf_gnt0 <= r_perf_gnt0 + 16'd1;
      end
      if (w_accept && w_grant[REQ_R1] && (r_perf_gnt1 != 16'hFFFF)) begin
        r_perf_gnt1 <= r_perf_gnt1 + 16'd1;
      end
      if (w_stall && (r_perf_stall != 16'hFFFF)) begin
        r_perf_stall <= r_perf_stall + 16'd1;
      end
    end
  end

  assign perf_gnt0  = r_perf_gnt0;
  assign perf_gnt1  = r_perf_gnt1;
  assign perf_stall = r_perf_stall;
`endif

endmodule
`default_nettype wire
